// File: rtl/block_memory.sv
// block_memory
//   Block-granular backing memory placed directly downstream of the
//   set-associative cache. Each transaction moves one full cache block
//   (2**c_block_size words of c_line_size bits) and completes after a fixed
//   access_latency. Serves line fills (reads) and dirty-line write-backs
//   (writes) over the cache's memory handshake.
//
// Handshake: m_read_i / m_wr_i are level requests held by the requester until
//   the matching done pulse. A request is accepted on an IDLE edge, at which
//   point address and write data are captured. m_busywait_o is high from the
//   acceptance edge until the completion edge. On the completion edge
//   m_busywait_o falls and exactly one of m_read_done_o / m_write_done_o pulses
//   for one cycle. m_read_data_o is valid during m_read_done_o and holds its
//   value until the next read completes. Requests are not sampled while BUSY
//   or DONE. If both requests are high in IDLE, the write is taken.
//
// Ports:
//   clk_i           clock, rising edge
//   reset_ni        asynchronous active-low reset
//   m_read_i        block read request
//   m_wr_i          block write request
//   m_address_i     block address (low mem_depth_log2 bits index the array)
//   m_write_data_i  block write data
//   m_read_data_o   block read data
//   m_busywait_o    transaction in progress
//   m_read_done_o   one-cycle read completion pulse
//   m_write_done_o  one-cycle write completion pulse
//   state_o         debug view of the FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Configuration macro: MEM_CLEAR_ON_RESET_EN
//   defined     -> reset asynchronously clears every array entry to zero
//   not defined -> the array is not reset; contents persist across reset

module block_memory #(
   parameter int c_line_size    = 32,
   parameter int c_block_size   = 2,
   parameter int address_size   = 32,
   parameter int mem_depth_log2 = 6,
   parameter int access_latency = 4
) (
   input  logic                                          clk_i,
   input  logic                                          reset_ni,
   input  logic                                          m_read_i,
   input  logic                                          m_wr_i,
   input  logic [address_size-c_block_size-3:0]          m_address_i,
   input  logic [(2**c_block_size)*c_line_size-1:0]      m_write_data_i,
   output logic [(2**c_block_size)*c_line_size-1:0]      m_read_data_o,
   output logic                                          m_busywait_o,
   output logic                                          m_read_done_o,
   output logic                                          m_write_done_o,
   output logic [1:0]                                    state_o
);

   localparam int BLOCK_W = (2**c_block_size) * c_line_size;
   localparam int ADDR_W  = address_size - c_block_size - 2;
   localparam int DEPTH   = 2**mem_depth_log2;
   localparam logic [7:0] LAT_M1 = 8'(access_latency - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                      state_q;
   logic [7:0]                  cnt_q;
   logic                        op_wr_q;
   logic [mem_depth_log2-1:0]   idx_q;
   logic [BLOCK_W-1:0]          wdata_q;
   logic [BLOCK_W-1:0]          mem [DEPTH];
   logic                        mem_we;

   // Upper address bits alias onto the array and are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^m_address_i[ADDR_W-1:mem_depth_log2];

   assign state_o = state_q;

   // The array write happens on the same edge the FSM leaves BUSY.
   assign mem_we = (state_q == S_BUSY) && (cnt_q == 8'd0) && op_wr_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q        <= S_IDLE;
         cnt_q          <= 8'd0;
         op_wr_q        <= 1'b0;
         idx_q          <= '0;
         wdata_q        <= '0;
         m_busywait_o   <= 1'b0;
         m_read_done_o  <= 1'b0;
         m_write_done_o <= 1'b0;
         m_read_data_o  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (m_wr_i || m_read_i) begin
                  // Write has priority over a simultaneous read.
                  op_wr_q      <= m_wr_i;
                  idx_q        <= m_address_i[mem_depth_log2-1:0];
                  if (m_wr_i) wdata_q <= m_write_data_i;
                  cnt_q        <= LAT_M1;
                  m_busywait_o <= 1'b1;
                  state_q      <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt_q == 8'd0) begin
                  if (!op_wr_q) m_read_data_o <= mem[idx_q];
                  m_busywait_o   <= 1'b0;
                  m_read_done_o  <= !op_wr_q;
                  m_write_done_o <= op_wr_q;
                  state_q        <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            S_DONE: begin
               m_read_done_o  <= 1'b0;
               m_write_done_o <= 1'b0;
               state_q        <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef MEM_CLEAR_ON_RESET_EN
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end
`else
   // No reset on the array: an in-flight write cancelled by reset never
   // reaches mem_we because the FSM is forced back to IDLE.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[idx_q] <= wdata_q;
   end
`endif

endmodule

// File: tb/tb_block_memory.sv
// tb_block_memory
//   Directed bench for block_memory with default parameters (latency 4,
//   64-entry array). Reads push their expected block into exp_q when issued
//   and pop it when m_read_done_o arrives. A shadow array tracks written data.

module tb_block_memory;

   localparam int LW  = 32;
   localparam int BS  = 2;
   localparam int AS  = 32;
   localparam int DL  = 6;
   localparam int LAT = 4;
   localparam int BW  = (2**BS) * LW;
   localparam int AW  = AS - BS - 2;

   logic          clk_i = 1'b0;
   logic          reset_ni;
   logic          m_read_i;
   logic          m_wr_i;
   logic [AW-1:0] m_address_i;
   logic [BW-1:0] m_write_data_i;
   logic [BW-1:0] m_read_data_o;
   logic          m_busywait_o;
   logic          m_read_done_o;
   logic          m_write_done_o;
   logic [1:0]    state_o;

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] model_mem [64];
   logic [BW-1:0] last_read;
   int            n_checks = 0;
   int            n_err    = 0;

   block_memory #(
      .c_line_size(LW), .c_block_size(BS), .address_size(AS),
      .mem_depth_log2(DL), .access_latency(LAT)
   ) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .m_read_i(m_read_i), .m_wr_i(m_wr_i),
      .m_address_i(m_address_i), .m_write_data_i(m_write_data_i),
      .m_read_data_o(m_read_data_o), .m_busywait_o(m_busywait_o),
      .m_read_done_o(m_read_done_o), .m_write_done_o(m_write_done_o),
      .state_o(state_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction. do_wr/do_rd drive the request lines; when both are set
   // the write is expected to win. perturb drops requests and scrambles the
   // address/data right after acceptance to show the latched values are used.
   task automatic txn(input bit do_wr, input bit do_rd, input logic [AW-1:0] addr,
                      input logic [BW-1:0] data, input bit perturb);
      logic [5:0]    idx;
      logic [BW-1:0] exp;
      idx = addr[5:0];
      @(negedge clk_i);
      m_wr_i         = do_wr;
      m_read_i       = do_rd;
      m_address_i    = addr;
      m_write_data_i = data;
      if (!do_wr) exp_q.push_back(model_mem[idx]);
      @(posedge clk_i); #1;
      check("accept_busywait", BW'(m_busywait_o), BW'(1));
      check("accept_state", BW'(state_o), BW'(1));
      if (do_wr) model_mem[idx] = data;
      if (perturb) begin
         m_wr_i         = 1'b0;
         m_read_i       = 1'b0;
         m_address_i    = AW'($urandom);
         m_write_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int c = 1; c < LAT; c++) begin
         @(posedge clk_i); #1;
         check("busy_busywait", BW'(m_busywait_o), BW'(1));
         check("busy_dones", BW'({m_read_done_o, m_write_done_o}), BW'(0));
      end
      @(posedge clk_i); #1;
      check("done_busywait", BW'(m_busywait_o), BW'(0));
      check("done_write_done", BW'(m_write_done_o), BW'(do_wr));
      check("done_read_done", BW'(m_read_done_o), BW'(!do_wr));
      check("done_state", BW'(state_o), BW'(2));
      if (!do_wr) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", BW'(exp_q.size()), BW'(1));
         end else begin
            exp = exp_q.pop_front();
            check("read_data", m_read_data_o, exp);
            last_read = exp;
         end
      end else begin
         check("read_data_held", m_read_data_o, last_read);
      end
      m_wr_i   = 1'b0;
      m_read_i = 1'b0;
      @(posedge clk_i); #1;
      check("after_dones", BW'({m_read_done_o, m_write_done_o}), BW'(0));
      check("after_state", BW'(state_o), BW'(0));
   endtask

   initial begin
      logic [BW-1:0] data_a;
      logic [BW-1:0] rnd_data;
      logic [AW-1:0] rnd_addr;

      reset_ni       = 1'b0;
      m_read_i       = 1'b0;
      m_wr_i         = 1'b0;
      m_address_i    = '0;
      m_write_data_i = '0;
      last_read      = '0;
`ifdef MEM_CLEAR_ON_RESET_EN
      for (int i = 0; i < 64; i++) model_mem[i] = '0;
`endif

      // reset values
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_busywait", BW'(m_busywait_o), BW'(0));
      check("reset_dones", BW'({m_read_done_o, m_write_done_o}), BW'(0));
      check("reset_read_data", m_read_data_o, '0);
      check("reset_state", BW'(state_o), BW'(0));
      @(negedge clk_i);
      reset_ni = 1'b1;

      // write then read block 0x1
      txn(1'b1, 1'b0, 28'h1, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001, 1'b0);
      txn(1'b0, 1'b1, 28'h1, '0, 1'b0);

      // aliasing: 0x41 and 0x01 share an entry
      txn(1'b1, 1'b0, 28'h41, 128'h4141_0000_1111_2222_3333_4444_5555_6666, 1'b0);
      txn(1'b0, 1'b1, 28'h01, '0, 1'b0);

      // simultaneous read and write: write wins
      txn(1'b1, 1'b1, 28'h5, 128'h0505_A5A5_5A5A_F00D_CAFE_0000_1234_5678, 1'b0);
      txn(1'b0, 1'b1, 28'h5, '0, 1'b0);

      // requests dropped and inputs scrambled during BUSY
      txn(1'b1, 1'b0, 28'h9, 128'h9999_8888_7777_6666_5555_4444_3333_2222, 1'b1);
      txn(1'b0, 1'b1, 28'h9, '0, 1'b1);

      // reset during BUSY of a write to 0x7
      data_a = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0007;
      txn(1'b1, 1'b0, 28'h7, data_a, 1'b0);
      @(negedge clk_i);
      m_wr_i         = 1'b1;
      m_address_i    = 28'h7;
      m_write_data_i = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
      @(posedge clk_i); #1;
      check("rst_txn_accept", BW'(m_busywait_o), BW'(1));
      @(posedge clk_i); #2;
      reset_ni = 1'b0;
      #1;
      check("midrst_busywait", BW'(m_busywait_o), BW'(0));
      check("midrst_dones", BW'({m_read_done_o, m_write_done_o}), BW'(0));
      check("midrst_read_data", m_read_data_o, '0);
      check("midrst_state", BW'(state_o), BW'(0));
      m_wr_i = 1'b0;
      @(negedge clk_i);
      reset_ni  = 1'b1;
      last_read = '0;
`ifdef MEM_CLEAR_ON_RESET_EN
      for (int i = 0; i < 64; i++) model_mem[i] = '0;
`endif
      txn(1'b0, 1'b1, 28'h7, '0, 1'b0);

      // random write/read pairs, reads through an aliased address
      for (int k = 0; k < 6; k++) begin
         rnd_addr = AW'($urandom);
         rnd_data = {$urandom, $urandom, $urandom, $urandom};
         txn(1'b1, 1'b0, rnd_addr, rnd_data, 1'($urandom_range(0, 1)));
         txn(1'b0, 1'b1, {AW'($urandom_range(0, 1000)), rnd_addr[5:0]} , '0, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
